// File: rtl/bitstream_pkg.sv
// Shared types and sizing helpers for the parallel-to-serial bitstream serializer.
package bitstream_pkg;

  localparam int DEFAULT_BITSTREAM = 64;

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  // Width able to hold 0..n inclusive; an all-ones stream needs the extra bit.
  function automatic int count_width(input int n);
    return $clog2(n) + 1;
  endfunction

endpackage

// File: rtl/bitstream_serializer.sv
// Serializes parallel stochastic patterns LSB-first with a one-deep shadow buffer
// and reports the ones count of each completed stream.
//
// state | meaning
// IDLE  | no active stream, waiting for a pattern
// SHIFT | active stream emitting one bit per output handshake
module bitstream_serializer
  import bitstream_pkg::*;
#(
  parameter int BITSTREAM = DEFAULT_BITSTREAM
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [BITSTREAM-1:0]                in_pattern,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                out_bit,
  output logic                                out_first,
  output logic                                out_last,
  output logic [count_width(BITSTREAM)-1:0]   ones_count,
  output logic                                count_valid
);

  localparam int IW = $clog2(BITSTREAM);
  localparam int CW = count_width(BITSTREAM);
  localparam logic [IW-1:0] LAST_IDX = IW'(BITSTREAM - 1);

  state_t               state, state_nxt;
  logic [BITSTREAM-1:0] active;
  logic [BITSTREAM-1:0] shadow;
  logic                 shadow_full;
  logic [IW-1:0]        idx;
  logic [CW-1:0]        acc;
  logic [CW-1:0]        acc_plus;

  logic in_hs, out_hs, last_hs;
  logic load_in, load_sh2act, load_shadow, advance, go_idle;

  assign in_ready  = !shadow_full;
  assign out_valid = (state == SHIFT);
  assign out_bit   = out_valid & active[idx];
  assign out_first = out_valid && (idx == '0);
  assign out_last  = out_valid && (idx == LAST_IDX);

  assign in_hs    = in_valid && in_ready;
  assign out_hs   = out_valid && out_ready;
  assign last_hs  = out_hs && (idx == LAST_IDX);
  assign acc_plus = acc + CW'(out_bit);

  always_comb begin
    state_nxt   = state;
    load_in     = 1'b0;
    load_sh2act = 1'b0;
    load_shadow = 1'b0;
    advance     = 1'b0;
    go_idle     = 1'b0;
    case (state)
      IDLE: begin
        if (in_hs) begin
          load_in   = 1'b1;
          state_nxt = SHIFT;
        end
      end
      SHIFT: begin
        // At the stream boundary the shadow wins; otherwise a new input bypasses straight in.
        if (last_hs) begin
          if (shadow_full) begin
            load_sh2act = 1'b1;
          end else if (in_hs) begin
            load_in = 1'b1;
          end else begin
            go_idle   = 1'b1;
            state_nxt = IDLE;
          end
        end else begin
          advance     = out_hs;
          load_shadow = in_hs;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      active      <= '0;
      shadow      <= '0;
      shadow_full <= 1'b0;
      idx         <= '0;
    end else begin
      if (load_in) begin
        active <= in_pattern;
        idx    <= '0;
      end else if (load_sh2act) begin
        active      <= shadow;
        idx         <= '0;
        shadow_full <= 1'b0;
      end else if (go_idle) begin
        idx <= '0;
      end else if (advance) begin
        idx <= idx + IW'(1);
      end
      if (load_shadow) begin
        shadow      <= in_pattern;
        shadow_full <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc         <= '0;
      ones_count  <= '0;
      count_valid <= 1'b0;
    end else begin
      count_valid <= 1'b0;
      if (last_hs) begin
        ones_count  <= acc_plus;
        count_valid <= 1'b1;
        acc         <= '0;
      end else if (out_hs) begin
        acc <= acc_plus;
      end
    end
  end

endmodule

// File: tb/tb_bitstream_serializer.sv
// Directed self-checking bench for bitstream_serializer at BITSTREAM=64.
module tb_bitstream_serializer;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [63:0] in_pattern;
  logic        out_valid;
  logic        out_ready;
  logic        out_bit;
  logic        out_first;
  logic        out_last;
  logic [6:0]  ones_count;
  logic        count_valid;

  int errors = 0;
  int checks = 0;

  bitstream_serializer #(.BITSTREAM(64)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pattern (in_pattern),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_bit    (out_bit),
    .out_first  (out_first),
    .out_last   (out_last),
    .ones_count (ones_count),
    .count_valid(count_valid)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic test_reset();
    rst_n      = 1'b0;
    in_valid   = 1'b0;
    in_pattern = '0;
    out_ready  = 1'b0;
    repeat (2) @(negedge clk);
    checks++;
    if ({out_valid, out_bit, out_first, out_last, count_valid} !== 5'b0) begin
      errors++;
      $display("FAIL reset_outputs: got %b want 00000",
               {out_valid, out_bit, out_first, out_last, count_valid});
    end
    checks++;
    if (ones_count !== 7'd0) begin
      errors++;
      $display("FAIL reset_ones_count: got %0d want 0", ones_count);
    end
    rst_n = 1'b1;
    @(negedge clk);
    checks++;
    if (in_ready !== 1'b1) begin
      errors++;
      $display("FAIL reset_in_ready: got %b want 1", in_ready);
    end
  endtask

  task automatic test_basic_ff();
    logic [4:0] exp;
    in_valid   = 1'b1;
    in_pattern = 64'h0000_0000_0000_00FF;
    out_ready  = 1'b1;
    for (int cyc = 1; cyc <= 64; cyc++) begin
      @(negedge clk);
      in_valid = 1'b0;
      exp = {1'b1, (cyc <= 8), (cyc == 1), (cyc == 64), 1'b0};
      checks++;
      if ({out_valid, out_bit, out_first, out_last, count_valid} !== exp) begin
        errors++;
        $display("FAIL basic_cycle%0d: got %b want %b", cyc,
                 {out_valid, out_bit, out_first, out_last, count_valid}, exp);
      end
    end
    @(negedge clk);
    checks++;
    if ({out_valid, count_valid, ones_count} !== {1'b0, 1'b1, 7'd8}) begin
      errors++;
      $display("FAIL basic_count: got valid=%b cv=%b ones=%0d want valid=0 cv=1 ones=8",
               out_valid, count_valid, ones_count);
    end
    @(negedge clk);
    checks++;
    if ({count_valid, ones_count} !== {1'b0, 7'd8}) begin
      errors++;
      $display("FAIL basic_hold: got cv=%b ones=%0d want cv=0 ones=8", count_valid, ones_count);
    end
  endtask

  task automatic test_back_to_back();
    logic [5:0] exp;
    @(negedge clk);
    in_valid   = 1'b1;
    in_pattern = '1;
    out_ready  = 1'b1;
    for (int cyc = 1; cyc <= 128; cyc++) begin
      @(negedge clk);
      in_valid   = (cyc == 1);
      in_pattern = (cyc == 1) ? 64'h0 : 64'hDEAD_BEEF_0BAD_F00D;
      exp = {1'b1, (cyc <= 64), (cyc == 1 || cyc == 65), (cyc == 64 || cyc == 128),
             (cyc == 65), (cyc == 1 || cyc >= 65)};
      checks++;
      if ({out_valid, out_bit, out_first, out_last, count_valid, in_ready} !== exp) begin
        errors++;
        $display("FAIL b2b_cycle%0d: got %b want %b", cyc,
                 {out_valid, out_bit, out_first, out_last, count_valid, in_ready}, exp);
      end
      if (cyc == 65) begin
        checks++;
        if (ones_count !== 7'd64) begin
          errors++;
          $display("FAIL b2b_count_first: got %0d want 64", ones_count);
        end
      end
    end
    @(negedge clk);
    checks++;
    if ({out_valid, count_valid, ones_count} !== {1'b0, 1'b1, 7'd0}) begin
      errors++;
      $display("FAIL b2b_count_second: got valid=%b cv=%b ones=%0d want valid=0 cv=1 ones=0",
               out_valid, count_valid, ones_count);
    end
  endtask

  task automatic test_stalls();
    int   exp_idx = 0;
    int   cycles  = 0;
    logic prev_bit = 1'b0;
    logic prev_stall = 1'b0;
    logic [3:0] exp;
    @(negedge clk);
    in_valid   = 1'b1;
    in_pattern = 64'hAAAA_AAAA_AAAA_AAAA;
    out_ready  = 1'b0;
    while (exp_idx < 64 && cycles < 2000) begin
      @(negedge clk);
      cycles++;
      in_valid   = 1'b0;
      in_pattern = {$urandom, $urandom};
      exp = {1'b1, exp_idx[0], (exp_idx == 0), (exp_idx == 63)};
      checks++;
      if ({out_valid, out_bit, out_first, out_last} !== exp) begin
        errors++;
        $display("FAIL stall_idx%0d: got %b want %b", exp_idx,
                 {out_valid, out_bit, out_first, out_last}, exp);
      end
      if (prev_stall) begin
        checks++;
        if (out_bit !== prev_bit) begin
          errors++;
          $display("FAIL stall_hold: got %b want %b", out_bit, prev_bit);
        end
      end
      prev_bit   = out_bit;
      out_ready  = 1'($urandom_range(0, 1));
      prev_stall = !out_ready;
      if (out_ready) exp_idx++;
    end
    checks++;
    if (exp_idx != 64) begin
      errors++;
      $display("FAIL stall_timeout: got idx %0d want 64", exp_idx);
    end
    @(negedge clk);
    out_ready = 1'b1;
    checks++;
    if ({out_valid, count_valid, ones_count} !== {1'b0, 1'b1, 7'd32}) begin
      errors++;
      $display("FAIL stall_count: got valid=%b cv=%b ones=%0d want valid=0 cv=1 ones=32",
               out_valid, count_valid, ones_count);
    end
  endtask

  task automatic test_bypass();
    logic [63:0] p2;
    logic [5:0]  exp;
    p2 = 64'h8000_0000_0000_0003;
    @(negedge clk);
    in_valid   = 1'b1;
    in_pattern = 64'h0000_0000_0000_0001;
    out_ready  = 1'b1;
    for (int cyc = 1; cyc <= 128; cyc++) begin
      @(negedge clk);
      in_valid   = (cyc == 64);
      in_pattern = (cyc == 64) ? p2 : 64'h0;
      exp = {1'b1, (cyc <= 64) ? (cyc == 1) : p2[cyc-65], (cyc == 1 || cyc == 65),
             (cyc == 64 || cyc == 128), (cyc == 65), 1'b1};
      checks++;
      if ({out_valid, out_bit, out_first, out_last, count_valid, in_ready} !== exp) begin
        errors++;
        $display("FAIL bypass_cycle%0d: got %b want %b", cyc,
                 {out_valid, out_bit, out_first, out_last, count_valid, in_ready}, exp);
      end
      if (cyc == 65) begin
        checks++;
        if (ones_count !== 7'd1) begin
          errors++;
          $display("FAIL bypass_count_first: got %0d want 1", ones_count);
        end
      end
    end
    @(negedge clk);
    checks++;
    if ({out_valid, count_valid, ones_count} !== {1'b0, 1'b1, 7'd3}) begin
      errors++;
      $display("FAIL bypass_count_second: got valid=%b cv=%b ones=%0d want valid=0 cv=1 ones=3",
               out_valid, count_valid, ones_count);
    end
  endtask

  task automatic test_reset_midstream();
    int          cv_seen = 0;
    logic [63:0] p3;
    logic [4:0]  exp;
    p3 = 64'h0000_0000_0000_0005;
    @(negedge clk);
    in_valid   = 1'b1;
    in_pattern = '1;
    out_ready  = 1'b1;
    for (int cyc = 1; cyc <= 31; cyc++) begin
      @(negedge clk);
      in_valid   = (cyc == 1);
      in_pattern = 64'hFFFF_0000_FFFF_0000;
    end
    checks++;
    if ({out_valid, out_bit, in_ready} !== 3'b110) begin
      errors++;
      $display("FAIL midrst_pre: got %b want 110", {out_valid, out_bit, in_ready});
    end
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if ({out_valid, out_bit, out_first, out_last, count_valid, ones_count} !== 12'd0) begin
      errors++;
      $display("FAIL midrst_immediate: got %b want 0",
               {out_valid, out_bit, out_first, out_last, count_valid, ones_count});
    end
    in_valid = 1'b0;
    repeat (2) begin
      @(negedge clk);
      if (count_valid) cv_seen++;
    end
    rst_n = 1'b1;
    @(negedge clk);
    if (count_valid) cv_seen++;
    checks++;
    if (cv_seen != 0) begin
      errors++;
      $display("FAIL midrst_no_pulse: got %0d pulses want 0", cv_seen);
    end
    checks++;
    if ({in_ready, out_valid} !== 2'b10) begin
      errors++;
      $display("FAIL midrst_release: got ready/valid %b want 10", {in_ready, out_valid});
    end
    in_valid   = 1'b1;
    in_pattern = p3;
    for (int cyc = 1; cyc <= 64; cyc++) begin
      @(negedge clk);
      in_valid = 1'b0;
      exp = {1'b1, p3[cyc-1], (cyc == 1), (cyc == 64), 1'b0};
      checks++;
      if ({out_valid, out_bit, out_first, out_last, count_valid} !== exp) begin
        errors++;
        $display("FAIL midrst_stream%0d: got %b want %b", cyc,
                 {out_valid, out_bit, out_first, out_last, count_valid}, exp);
      end
    end
    @(negedge clk);
    checks++;
    if ({out_valid, count_valid, ones_count} !== {1'b0, 1'b1, 7'd2}) begin
      errors++;
      $display("FAIL midrst_count: got valid=%b cv=%b ones=%0d want valid=0 cv=1 ones=2",
               out_valid, count_valid, ones_count);
    end
  endtask

  initial begin
    test_reset();
    test_basic_ff();
    test_back_to_back();
    test_stalls();
    test_bypass();
    test_reset_midstream();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/bitstream_serializer.md
BITSTREAM_SERIALIZER -- requirements
Module: bitstream_serializer

Interface
REQ-001 SHALL have parameter BITSTREAM, default 64, stream length in bits; legal values are powers of two from 2 to 1024.
REQ-002 SHALL have ports clk (input, 1): the single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_n (input, 1): asynchronous, active-low reset.
REQ-004 SHALL have port in_valid (input, 1): in_pattern holds a valid parallel bitstream pattern.
REQ-005 SHALL have port in_ready (output, 1): block can accept a pattern this cycle.
REQ-006 SHALL have port in_pattern (input, BITSTREAM): parallel stochastic pattern from the Weyl mask stage.
REQ-007 SHALL have port out_valid (output, 1): out_bit is valid.
REQ-008 SHALL have port out_ready (input, 1): downstream consumes out_bit this cycle.
REQ-009 SHALL have port out_bit (output, 1): current serial stream bit.
REQ-010 SHALL have port out_first (output, 1): out_bit is bit index 0 of a stream.
REQ-011 SHALL have port out_last (output, 1): out_bit is bit index BITSTREAM-1.
REQ-012 SHALL have port ones_count (output, $clog2(BITSTREAM)+1): number of ones in the last completed stream.
REQ-013 SHALL have port count_valid (output, 1): one-cycle pulse when ones_count updates.

Function
REQ-014 SHALL hold an active shift register with a bit index, and a shadow register with a full flag.
REQ-015 SHALL use states IDLE (no active stream) and SHIFT (active stream emitting).
REQ-016 SHALL drive in_ready = !shadow_full; an input handshake is in_valid && in_ready.
REQ-017 IDLE + input handshake: pattern SHALL load into active, index 0, next state SHIFT; out_valid is high the following cycle (latency 1).
REQ-018 SHIFT + input handshake (not last-bit cycle): pattern SHALL load into shadow; shadow_full is set.
REQ-019 In SHIFT, out_valid SHALL be 1 and out_bit SHALL equal active[index], LSB (index 0) first.
REQ-020 On output handshake (out_valid && out_ready), index SHALL increment; without handshake, out_bit, out_first, out_last and index SHALL hold.
REQ-021 out_first SHALL equal (index==0) and out_last SHALL equal (index==BITSTREAM-1), both gated by out_valid.
REQ-022 Last-bit handshake with shadow_full: shadow SHALL move to active, index 0, shadow_full cleared, state stays SHIFT; no gap cycle.
REQ-023 Last-bit handshake with shadow empty and a simultaneous input handshake: input SHALL bypass directly into active, index 0, state stays SHIFT.
REQ-024 Last-bit handshake with neither condition: next state SHALL be IDLE, out_valid low next cycle.
REQ-025 A ones accumulator SHALL add out_bit on every output handshake.
REQ-026 On last-bit handshake, ones_count SHALL register accumulator+out_bit, count_valid SHALL pulse the next cycle, and the accumulator SHALL clear.
REQ-027 ones_count SHALL hold between pulses; all-zero pattern yields 0, all-one pattern yields BITSTREAM (no overflow).
REQ-028 in_pattern SHALL be sampled only on an input handshake; changes at other times have no effect.

Reset
REQ-029 rst_n low SHALL immediately force IDLE, clear shadow_full, index, accumulator, out_valid, out_first, out_last, out_bit, ones_count and count_valid to 0.
REQ-030 in_ready SHALL be 1 from the first cycle after reset release.
REQ-031 Reset mid-stream SHALL discard the active and shadow patterns with no count_valid pulse.

Structure
REQ-032 Package bitstream_pkg SHALL hold the state enum typedef, default BITSTREAM, and the count-width constant function.
REQ-033 SHALL be a single module with no sub-module; shift, shadow, FSM and accumulator are local.

Verification
REQ-034 Load 64'h0000_0000_0000_00FF with out_ready=1 -> out_bit 1 for 8 cycles then 0 for 56; out_first on cycle 1, out_last on cycle 64; ones_count=8 with count_valid pulse.
REQ-035 Two back-to-back patterns (all-ones, then all-zeros) -> second loads into shadow, in_ready low until the first stream's last bit; 128 contiguous out_valid cycles; counts 64 then 0.
REQ-036 Random out_ready stalls (50%) on pattern 64'hAAAA_AAAA_AAAA_AAAA -> out_bit stable during stalls, alternating 0/1 on handshakes, ones_count=32.
REQ-037 in_valid asserted on the exact last-bit handshake with shadow empty -> bypass load, next cycle out_first=1 with no idle gap.
REQ-038 rst_n pulsed low at bit index 30 with shadow full -> all outputs 0 immediately, no count_valid; in_ready=1 after release; next pattern streams from index 0.
